// File: rtl/bb_mem_arbiter_pkg.sv
// bb_mem_arbiter_pkg: action codes, FSM state encoding and default widths shared by the memory arbiter files
package bb_mem_arbiter_pkg;
  localparam int DEF_NUM_CH = 2;
  localparam int DEF_DW = 32;
  localparam int DEF_AW = 32;
  localparam int DEF_RD_LAT = 1;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {
    MEM_IDLE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10,
    MEM_RSVD  = 2'b11
  } mem_action_e;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } state_e;
endpackage

// File: rtl/bb_rr_arbiter.sv
// bb_rr_arbiter: combinational round-robin pick; req vector + last grant in, one-hot gnt / binary idx / any out
module bb_rr_arbiter #(
  parameter int NUM_CH = 2,
  localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     last,
  output logic [NUM_CH-1:0] gnt,
  output logic [IW-1:0]     idx,
  output logic              any
);
  logic [NUM_CH-1:0] rot;
  always_comb begin
    rot = NUM_CH'({req, req} >> (int'(last) + 1));
    idx = '0;
    any = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        idx = IW'((int'(last) + 1 + i) % NUM_CH);
        any = 1'b1;
      end
    end
    gnt = any ? NUM_CH'(1) << idx : '0;
  end
endmodule

// File: rtl/bb_mem_arbiter.sv
// bb_mem_arbiter: serialises NUM_CH i_action/i_addr/i_data requesters onto one mem_r_*/mem_w_* port, replying via o_ready/o_rsp_valid/o_rsp_data
module bb_mem_arbiter
  import bb_mem_arbiter_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*NUM_CH-1:0]  i_action,
  input  logic [AW*NUM_CH-1:0] i_addr,
  input  logic [DW*NUM_CH-1:0] i_data,
  output logic [NUM_CH-1:0]    o_ready,
  output logic [NUM_CH-1:0]    o_rsp_valid,
  output logic [DW-1:0]        o_rsp_data,
  output logic                 mem_r_en,
  output logic [AW-1:0]        mem_r_addr,
  input  logic [DW-1:0]        mem_r_data,
  output logic                 mem_w_en,
  output logic [AW-1:0]        mem_w_addr,
  output logic [DW-1:0]        mem_w_data
);
  localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  state_e state_q, state_d;
  logic [IW-1:0] last_q, last_d, gidx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0] r_addr_q, r_addr_d, w_addr_q, w_addr_d;
  logic [DW-1:0] w_data_q, w_data_d, rsp_q, rsp_d;
  logic [NUM_CH-1:0] req, gnt;
  logic any;
  logic [1:0] sel_act;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  always_comb begin
    req = '0;
    for (int k = 0; k < NUM_CH; k++) req[k] = i_action[2*k+:2] == MEM_READ || i_action[2*k+:2] == MEM_WRITE;
  end
  bb_rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req (req),
    .last(last_q),
    .gnt (gnt),
    .idx (gidx),
    .any (any)
  );
  always_comb begin
    sel_act = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (gnt[k]) begin
        sel_act = i_action[2*k+:2];
        sel_addr = i_addr[AW*k+:AW];
        sel_data = i_data[DW*k+:DW];
      end
    end
  end
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    cnt_d = cnt_q;
    r_addr_d = r_addr_q;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    rsp_d = rsp_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          last_d = gidx;
          state_d = sel_act == MEM_WRITE ? WR : RD;
          w_addr_d = sel_act == MEM_WRITE ? sel_addr : w_addr_q;
          w_data_d = sel_act == MEM_WRITE ? sel_data : w_data_q;
          r_addr_d = sel_act == MEM_WRITE ? r_addr_q : sel_addr;
        end
      end
      WR: state_d = IDLE;
      RD: begin
        cnt_d = CNT_W'(RD_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        rsp_d = cnt_q == '0 ? mem_r_data : rsp_q;
        state_d = cnt_q == '0 ? RESP : WAIT;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= IW'(NUM_CH - 1);
      cnt_q <= '0;
      r_addr_q <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
      rsp_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      r_addr_q <= r_addr_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      rsp_q <= rsp_d;
    end
  end
  assign o_ready = state_q == IDLE && !rst ? gnt : '0;
  assign o_rsp_valid = state_q == RESP ? NUM_CH'(1) << last_q : '0;
  assign o_rsp_data = rsp_q;
  assign mem_r_en = state_q == RD;
  assign mem_r_addr = r_addr_q;
  assign mem_w_en = state_q == WR;
  assign mem_w_addr = w_addr_q;
  assign mem_w_data = w_data_q;
endmodule
